// File: rtl/kbd_event_decoder.sv
// PS/2 set-2 scancode to key-event decoder with a show-ahead event FIFO.
// Optional auto-repeat suppression: define KBD_EVT_TYPEMATIC_FILTER_EN.
`timescale 1ns/1ps
module kbd_event_decoder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          kbd_ready,
    input  logic [7:0]    kbd_data,
    output logic          kbd_read,
    input  logic          ev_read,
    output logic          ev_valid,
    output logic [9:0]    ev_data,
    output logic [AW:0]   ev_count,
    output logic          ev_ovf,
    input  logic          ovf_clr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXT    = 3'd1,
        S_BRK    = 3'd2,
        S_EXTBRK = 3'd3,
        S_PAUSE  = 3'd4
    } state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic          ev_req_s;
    logic [9:0]    ev_word_s;
    logic          push_req_s;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          valid_q, ovf_q, ovf_d;
    logic [9:0]    head_q, head_d;
    logic          pop_s, full_s, push_s, drop_s;

    assign kbd_read = kbd_ready & clrn;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (kbd_ready) begin
            case (state_q)
                S_IDLE: begin
                    case (kbd_data)
                        8'hE0:   state_d = S_EXT;
                        8'hF0:   state_d = S_BRK;
                        8'hE1: begin
                            state_d = S_PAUSE;
                            skip_d  = 3'd7;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
                S_EXT: begin
                    if (kbd_data == 8'hF0) state_d = S_EXTBRK;
                    else                   state_d = S_IDLE;
                end
                S_BRK, S_EXTBRK: state_d = S_IDLE;
                S_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = S_IDLE;
                    else                state_d = S_PAUSE;
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Event produced by the byte consumed this cycle, if it completes one.
    always_comb begin
        ev_req_s  = 1'b0;
        ev_word_s = 10'h000;
        if (kbd_ready) begin
            case (state_q)
                S_IDLE: begin
                    case (kbd_data)
                        8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA,
                        8'hEE, 8'hFC, 8'h00, 8'hFF: ev_req_s = 1'b0;
                        default: begin
                            ev_req_s  = 1'b1;
                            ev_word_s = {2'b00, kbd_data};
                        end
                    endcase
                end
                S_EXT: begin
                    if (kbd_data != 8'hF0) begin
                        ev_req_s  = 1'b1;
                        ev_word_s = {2'b01, kbd_data};
                    end else begin
                        ev_req_s  = 1'b0;
                    end
                end
                S_BRK: begin
                    ev_req_s  = 1'b1;
                    ev_word_s = {2'b10, kbd_data};
                end
                S_EXTBRK: begin
                    ev_req_s  = 1'b1;
                    ev_word_s = {2'b11, kbd_data};
                end
                S_PAUSE: begin
                    if (skip_q == 3'd1) begin
                        ev_req_s  = 1'b1;
                        ev_word_s = 10'h1E1;
                    end else begin
                        ev_req_s  = 1'b0;
                    end
                end
                default: ev_req_s = 1'b0;
            endcase
        end else begin
            ev_req_s = 1'b0;
        end
    end

`ifdef KBD_EVT_TYPEMATIC_FILTER_EN
    logic       held_v_q, held_v_d;
    logic [8:0] held_k_q, held_k_d;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held_v_q <= 1'b0;
            held_k_q <= 9'h000;
        end else begin
            held_v_q <= held_v_d;
            held_k_q <= held_k_d;
        end
    end

    // Pause events skip the filter; only make/break of ordinary keys touch it.
    always_comb begin
        push_req_s = ev_req_s;
        held_v_d   = held_v_q;
        held_k_d   = held_k_q;
        if (ev_req_s && (state_q != S_PAUSE)) begin
            if (!ev_word_s[9]) begin
                if (held_v_q && (held_k_q == ev_word_s[8:0])) begin
                    push_req_s = 1'b0;
                end else begin
                    held_v_d = 1'b1;
                    held_k_d = ev_word_s[8:0];
                end
            end else if (held_v_q && (held_k_q == ev_word_s[8:0])) begin
                held_v_d = 1'b0;
            end else begin
                held_v_d = held_v_q;
            end
        end else begin
            push_req_s = ev_req_s;
        end
    end
`else
    assign push_req_s = ev_req_s;
`endif

    assign pop_s  = ev_read & valid_q;
    assign full_s = (count_q == DEPTH_C);
    assign push_s = push_req_s & (~full_s | pop_s);
    assign drop_s = push_req_s & full_s & ~pop_s;

    // A head slot being written this cycle is forwarded from the pushed word.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        if (push_s && !pop_s)      count_d = count_q + CNT_ONE;
        else if (!push_s && pop_s) count_d = count_q - CNT_ONE;
        else                       count_d = count_q;
        if (count_d == {(AW+1){1'b0}})           head_d = 10'h000;
        else if (push_s && rd_ptr_d == wr_ptr_q) head_d = ev_word_s;
        else                                     head_d = mem_q[rd_ptr_d];
        if (drop_s)       ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q] <= ev_word_s;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            valid_q  <= 1'b0;
            head_q   <= 10'h000;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != {(AW+1){1'b0}});
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ev_valid = valid_q;
    assign ev_data  = head_q;
    assign ev_count = count_q;
    assign ev_ovf   = ovf_q;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Directed + randomized bench for kbd_event_decoder against a byte-pattern reference model.
`timescale 1ns/1ps
module tb_kbd_event_decoder;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk, clrn, kbd_ready, kbd_read, ev_read, ev_valid, ev_ovf, ovf_clr;
    logic [7:0]  kbd_data;
    logic [9:0]  ev_data;
    logic [AW:0] ev_count;

    kbd_event_decoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .clrn(clrn), .kbd_ready(kbd_ready), .kbd_data(kbd_data),
        .kbd_read(kbd_read), .ev_read(ev_read), .ev_valid(ev_valid),
        .ev_data(ev_data), .ev_count(ev_count), .ev_ovf(ev_ovf), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending prefix bytes, queued events, overflow flag, held key.
    logic [7:0] pend[$];
    logic [9:0] fq[$];
    bit         movf;
    bit         hv;
    logic [8:0] hk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Interpret the pending byte sequence as a whole once it forms a complete pattern.
    task automatic model_byte(input logic [7:0] b, output bit ev, output logic [9:0] e, output bit pz);
        ev = 1'b0; e = 10'h000; pz = 1'b0;
        pend.push_back(b);
        if (pend[0] == 8'hE1) begin
            if (pend.size() == 8) begin ev = 1'b1; e = 10'h1E1; pz = 1'b1; pend.delete(); end
        end else if (pend[0] == 8'hE0) begin
            if (pend.size() == 2 && pend[1] != 8'hF0) begin
                ev = 1'b1; e = {2'b01, pend[1]}; pend.delete();
            end else if (pend.size() == 3) begin
                ev = 1'b1; e = {2'b11, pend[2]}; pend.delete();
            end
        end else if (pend[0] == 8'hF0) begin
            if (pend.size() == 2) begin ev = 1'b1; e = {2'b10, pend[1]}; pend.delete(); end
        end else begin
            if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF})) begin
                ev = 1'b1; e = {2'b00, b};
            end
            pend.delete();
        end
    endtask

    task automatic check_all(input string tag);
        logic [9:0] exp_d;
        exp_d = (fq.size() != 0) ? fq[0] : 10'h000;
        chk({tag, "_valid"}, 32'(ev_valid), 32'(fq.size() != 0));
        chk({tag, "_data"},  32'(ev_data),  32'(exp_d));
        chk({tag, "_count"}, 32'(ev_count), 32'(fq.size()));
        chk({tag, "_ovf"},   32'(ev_ovf),   32'(movf));
    endtask

    task automatic step(input bit rdy, input logic [7:0] b, input bit rd, input bit clr);
        bit ev, pz, dropped;
        logic [9:0] e;
        @(negedge clk);
        kbd_ready = rdy; kbd_data = b; ev_read = rd; ovf_clr = clr;
        #1;
        chk("kbd_read", 32'(kbd_read), 32'(rdy));
        ev = 1'b0; pz = 1'b0; e = 10'h000; dropped = 1'b0;
        if (rdy) model_byte(b, ev, e, pz);
`ifdef KBD_EVT_TYPEMATIC_FILTER_EN
        if (ev && !pz) begin
            if (!e[9]) begin
                if (hv && hk == e[8:0]) ev = 1'b0;
                else begin hv = 1'b1; hk = e[8:0]; end
            end else if (hv && hk == e[8:0]) begin
                hv = 1'b0;
            end
        end
`endif
        if (rd && fq.size() > 0) void'(fq.pop_front());
        if (ev) begin
            if (fq.size() < DEPTH) fq.push_back(e);
            else dropped = 1'b1;
        end
        if (dropped) movf = 1'b1;
        else if (clr) movf = 1'b0;
        @(posedge clk);
        #1;
        check_all("step");
        kbd_ready = 1'b0; ev_read = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        clrn = 1'b0; kbd_ready = 1'b1; kbd_data = 8'h6B;
        #1;
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_data",  32'(ev_data),  32'd0);
        chk("rst_count", 32'(ev_count), 32'd0);
        chk("rst_ovf",   32'(ev_ovf),   32'd0);
        chk("rst_kbd_read", 32'(kbd_read), 32'd0);
        pend.delete(); fq.delete(); movf = 1'b0; hv = 1'b0; hk = 9'h000;
        @(negedge clk);
        kbd_ready = 1'b0;
        clrn = 1'b1;
    endtask

    task automatic bytes(input logic [7:0] seq[$]);
        foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b0);
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        kbd_ready = 1'b0; kbd_data = 8'h00; ev_read = 1'b0; ovf_clr = 1'b0; clrn = 1'b0;
        do_reset();

        bytes('{8'h1C, 8'hF0, 8'h1C});
        chk("tp1_count", 32'(ev_count), 32'd2);
        chk("tp1_head", 32'(ev_data), 32'h01C);
        pops(1);
        chk("tp1_second", 32'(ev_data), 32'h21C);
        pops(1);

        bytes('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'hFA});
        chk("tp2_count", 32'(ev_count), 32'd2);
        chk("tp2_head", 32'(ev_data), 32'h175);
        pops(1);
        chk("tp2_second", 32'(ev_data), 32'h375);
        pops(1);

        bytes('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0});
        chk("tp3_nothing_yet", 32'(ev_count), 32'd0);
        bytes('{8'h77});
        chk("tp3_pause", 32'(ev_data), 32'h1E1);
        bytes('{8'h1C});
        chk("tp3_idle_after", 32'(ev_count), 32'd2);
        pops(2);

        for (int k = 0; k < 9; k++) step(1'b1, 8'(8'h15 + k), 1'b0, 1'b0);
        chk("tp4_count", 32'(ev_count), 32'd8);
        chk("tp4_ovf", 32'(ev_ovf), 32'd1);
        chk("tp4_head", 32'(ev_data), 32'h015);
        pops(7);
        chk("tp4_last", 32'(ev_data), 32'h01C);
        pops(1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("tp4_ovf_clr", 32'(ev_ovf), 32'd0);

        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
        step(1'b1, 8'h30, 1'b1, 1'b0);
        chk("tp5_count", 32'(ev_count), 32'd8);
        chk("tp5_no_ovf", 32'(ev_ovf), 32'd0);
        pops(7);
        chk("tp5_tail", 32'(ev_data), 32'h030);
        pops(1);
        bytes('{8'hE0});
        do_reset();
        bytes('{8'h6B});
        chk("tp5_after_rst", 32'(ev_data), 32'h06B);
        pops(1);

        bytes('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C});
`ifdef KBD_EVT_TYPEMATIC_FILTER_EN
        chk("tp6_count", 32'(ev_count), 32'd3);
`else
        chk("tp6_count", 32'(ev_count), 32'd5);
`endif
        pops(5);

        for (int i = 0; i < 1200; i++) begin
            logic [7:0] b;
            int r;
            r = int'($urandom_range(0, 11));
            case (r)
                0:       b = 8'hE0;
                1, 2:    b = 8'hF0;
                3:       b = 8'hE1;
                4:       b = 8'hAA;
                5, 6, 7: b = 8'(8'h10 + $urandom_range(0, 3));
                default: b = 8'($urandom);
            endcase
            if (i == 600) do_reset();
            step(($urandom % 4) != 0, b, ($urandom % 3) == 0, ($urandom % 10) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/kbd_event_decoder.md
Name: kbd_event_decoder

Overview:
- Sits directly downstream of ps2_kbd and upstream of mmio.
- Consumes raw PS/2 set-2 scancode bytes over the ready/read handshake.
- Collapses E0/F0/E1 prefix sequences into single key events (make/break, extended, code).
- Queues the events in a small show-ahead FIFO that the CPU drains through mmio.

Parameters:
- DEPTH, 8, event FIFO depth in entries; power of two, 2..64.
- AW, 3, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock (real_clk domain, same as ps2_kbd and mmio).
- clrn  input  1  asynchronous active-low reset.
- kbd_ready  input  1  ps2_kbd has a byte available on kbd_data.
- kbd_data  input  8  current head byte of the ps2_kbd FIFO.
- kbd_read  output  1  pops one byte from ps2_kbd.
- ev_read  input  1  mmio pops one event.
- ev_valid  output  1  event FIFO not empty.
- ev_data  output  10  head event: [9]=break, [8]=extended, [7:0]=scancode.
- ev_count  output  AW+1  number of queued events, 0..DEPTH.
- ev_ovf  output  1  sticky flag: an event was dropped because the FIFO was full.
- ovf_clr  input  1  clears ev_ovf.

Behaviour:
- Reset (clrn=0, asynchronous):
  - State IDLE; FIFO pointers and count 0; ev_valid=0; ev_count=0; ev_ovf=0; ev_data=0; skip counter 0.
  - Reset mid-sequence discards any partial prefix.
- Input handshake:
  - kbd_read = kbd_ready, combinational; 0 while clrn=0.
  - Every available byte is consumed in the cycle kbd_read=1. There is no backpressure toward ps2_kbd.
- Decoder FSM. A byte is processed only when kbd_ready=1:
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE (skip=7).
    - AA, FA, EE, FC, 00, FF are ignored and the state stays IDLE.
    - Any other byte b: push {0,0,b}; stay IDLE.
  - EXT: F0->EXTBRK; any other b: push {0,1,b}; go to IDLE.
  - BRK: any b: push {1,0,b}; go to IDLE.
  - EXTBRK: any b: push {1,1,b}; go to IDLE.
  - PAUSE: decrement skip on each byte. When the byte that brings skip to 0 arrives, push {0,1,8'hE1} and go to IDLE. Contents of the skipped bytes are not checked.
  - When kbd_ready=0 the state holds.
- Event latency: the event is written at the clock edge that consumes its final byte. ev_valid rises the following cycle, when the FIFO was empty.
- FIFO:
  - Show-ahead: ev_data is the head entry whenever ev_valid=1, and 0 when empty.
  - Pop happens on ev_read & ev_valid. ev_read while empty is ignored.
  - A push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle. The result is a simultaneous push+pop with count unchanged.
  - A push while full without a pop drops the event and sets ev_ovf. The FSM still advances normally.
  - Pointers wrap modulo DEPTH; count saturates at DEPTH.
- ev_ovf:
  - Set by a drop; cleared by ovf_clr.
  - When a drop and ovf_clr occur in the same cycle, set wins.
- All outputs except kbd_read are registered.

Optional Feature:
- Macro: KBD_EVT_TYPEMATIC_FILTER_EN.
- Defined: the block holds one "held key" register {valid, ext, code}.
  - A make event equal to the held key is suppressed: not pushed, no overflow.
  - A make event for a different key replaces the held key and is pushed.
  - A break of the held key clears the register.
  - Pause events bypass the filter.
  - Reset clears the register.
- Not defined: every make event is pushed, including auto-repeats. The filter logic is absent.

Test Plan:
- Bytes 1C, F0 1C -> events 0x01C then 0x21C; ev_count reaches 2; kbd_read high on each byte cycle.
- Bytes E0 75, E0 F0 75 -> events 0x175 then 0x375; bytes AA, FA in IDLE -> no event.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x1E1 after the 8th byte; FSM back in IDLE.
- Push 9 make codes 0x15..0x1D with DEPTH=8 and no reads -> ev_count=8, ev_ovf=1, head 0x015. Pop all -> last event 0x01C. Pulse ovf_clr -> ev_ovf=0.
- With FIFO full, a push and ev_read in the same cycle -> count stays 8, no overflow, new tail is the pushed event. Assert clrn low mid E0 prefix -> all outputs 0; next byte 6B -> event 0x06B (not extended).
- With KBD_EVT_TYPEMATIC_FILTER_EN: 1C 1C 1C F0 1C 1C -> events 0x01C, 0x21C, 0x01C. Without the macro -> five events.
